// File: rtl/prog_lut.sv
// prog_lut: programmable, registered code-conversion table.
// After reset the table sweeps itself to default contents (INIT), then serves
// valid/ready lookups with one cycle of latency and accepts software writes (RUN).
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready
// depends only on state, out_valid and out_ready (never on in_valid). While a
// result is held with out_ready low, out_data/out_valid stay stable.
module prog_lut #(
    parameter int IN_W      = 4,
    parameter int OUT_W     = 6,
    parameter int INIT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IN_W-1:0]  wr_addr,
    input  logic [OUT_W-1:0] wr_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             init_done,
    output logic [15:0]      lookup_cnt
);

    localparam int              DEPTH    = 1 << IN_W;
    localparam logic [IN_W-1:0] LAST_IDX = IN_W'(DEPTH - 1);

    // init_done is a registered copy of (state_q == ST_RUN) and serves as the
    // externally visible state indicator.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [IN_W-1:0]  sweep_idx;
    logic [OUT_W-1:0] table_q [DEPTH];
    logic             accept;
    logic             fwd_hit;
    logic [OUT_W-1:0] lookup_word;

    // Default content of entry k: zero, or k truncated/zero-extended to OUT_W.
    function automatic logic [OUT_W-1:0] default_word(input logic [IN_W-1:0] k);
        if (INIT_MODE == 1) begin
            return OUT_W'(k);
        end else begin
            return '0;
        end
    endfunction

    // State machine: sweep every entry once after reset, then run until next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            sweep_idx <= '0;
            init_done <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    sweep_idx <= sweep_idx + IN_W'(1);
                    if (sweep_idx == LAST_IDX) begin
                        state_q   <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q   <= ST_INIT;
                    sweep_idx <= '0;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    // Table storage: the sweep owns the write port in INIT, software owns it in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                table_q[sweep_idx] <= default_word(sweep_idx);
            end else if (wr_en) begin
                table_q[wr_addr] <= wr_data;
            end
        end
    end

    // Lookup read with forwarding of a same-cycle write to the requested entry.
    always_comb begin
        fwd_hit     = wr_en && (wr_addr == in_data);
        lookup_word = fwd_hit ? wr_data : table_q[in_data];
    end

    assign in_ready = (state_q == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Result register and accepted-lookup counter; out_data keeps its last value when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            lookup_cnt <= '0;
        end else begin
            if (accept) begin
                out_data   <= lookup_word;
                out_valid  <= 1'b1;
                lookup_cnt <= lookup_cnt + 16'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prog_lut.sv
// Testbench for prog_lut: directed scenarios plus random traffic, all checked
// against a transaction-level reference model (table array + expected-result queue).
module tb_prog_lut;

    localparam int IN_W      = 4;
    localparam int OUT_W     = 6;
    localparam int INIT_MODE = 1;
    localparam int DEPTH     = 1 << IN_W;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             wr_en;
    logic [IN_W-1:0]  wr_addr;
    logic [OUT_W-1:0] wr_data;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             init_done;
    logic [15:0]      lookup_cnt;

    prog_lut #(.IN_W(IN_W), .OUT_W(OUT_W), .INIT_MODE(INIT_MODE)) u_dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .init_done(init_done), .lookup_cnt(lookup_cnt)
    );

    // Second instance: narrow table with all-zero defaults.
    logic        rst_b;
    logic        wr_en_b;
    logic [2:0]  wr_addr_b;
    logic [1:0]  wr_data_b;
    logic        in_valid_b;
    logic        in_ready_b;
    logic [2:0]  in_data_b;
    logic        out_valid_b;
    logic        out_ready_b;
    logic [1:0]  out_data_b;
    logic        init_done_b;
    logic [15:0] lookup_cnt_b;

    prog_lut #(.IN_W(3), .OUT_W(2), .INIT_MODE(0)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .init_done(init_done_b), .lookup_cnt(lookup_cnt_b)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] m_tab [DEPTH];
    logic [OUT_W-1:0] m_last;
    int               init_left = DEPTH;
    int               m_cnt     = 0;
    int               acc_count = 0;
    bit               seen_rst  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] ref_default(input int k);
        if (INIT_MODE == 1) return OUT_W'(k % (1 << OUT_W));
        return '0;
    endfunction

    // One clock cycle: inputs set by the caller are applied to the model at the
    // edge; in_ready is checked at the falling edge, registered outputs at edge+1.
    task automatic tick();
        bit               rdy_m;
        bit               acc;
        logic [OUT_W-1:0] head;
        @(negedge clk);
        rdy_m = (init_left == 0) && (exp_q.size() == 0 || out_ready);
        if (seen_rst) check("in_ready", 32'(in_ready), 32'(rdy_m));
        acc = !rst && in_valid && rdy_m;
        @(posedge clk);
        if (rst) begin
            seen_rst  = 1'b1;
            init_left = DEPTH;
            exp_q.delete();
            m_last    = '0;
            m_cnt     = 0;
            acc_count = 0;
            for (int k = 0; k < DEPTH; k++) m_tab[k] = ref_default(k);
        end else if (init_left > 0) begin
            init_left--;
        end else begin
            if (exp_q.size() != 0 && out_ready) m_last = exp_q.pop_front();
            if (acc) begin
                if (wr_en && wr_addr == in_data) exp_q.push_back(wr_data);
                else exp_q.push_back(m_tab[in_data]);
                m_cnt = (m_cnt + 1) % 65536;
                acc_count++;
            end
            if (wr_en) m_tab[wr_addr] = wr_data;
        end
        #1;
        if (seen_rst) begin
            head = (exp_q.size() != 0) ? exp_q[0] : m_last;
            check("init_done", 32'(init_done), 32'(init_left == 0));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("out_data", 32'(out_data), 32'(head));
            check("lookup_cnt", 32'(lookup_cnt), 32'(m_cnt));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        in_valid = 1'b0;
        in_data  = '0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset_and_init(output int n_init);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_init = 0;
        while (init_done !== 1'b1 && n_init < 40) begin
            tick();
            n_init++;
        end
    endtask

    task automatic lookup(input int idx);
        in_valid = 1'b1;
        in_data  = IN_W'(idx);
        tick();
        in_valid = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst = 1'b1;
        drive_idle();
        rst_b = 1'b1; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
        in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;

        // 1: init length with identity defaults
        do_reset_and_init(n);
        check("t1_init_len", 32'(n), 32'(DEPTH));

        // 2: stream 0..15 back-to-back
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = IN_W'(i);
            tick();
            check("t2_data", 32'(out_data), 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("t2_cnt", 32'(lookup_cnt), 32'd16);

        // 3: write then read, and same-cycle write forwarding
        wr_en = 1'b1; wr_addr = 4'h3; wr_data = 6'h2A;
        tick();
        wr_en = 1'b0;
        lookup(3);
        check("t3_wr_read", 32'(out_data), 32'h2A);
        wr_en = 1'b1; wr_addr = 4'h5; wr_data = 6'h11;
        lookup(5);
        wr_en = 1'b0;
        check("t3_wr_fwd", 32'(out_data), 32'h11);
        tick();

        // 4: backpressure for 3 cycles with a pending request
        in_valid = 1'b1; in_data = 4'h7; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = IN_W'($urandom_range(0, DEPTH - 1));
            tick();
            check("t4_hold_data", 32'(out_data), 32'h07);
            check("t4_hold_ready", 32'(in_ready), 32'd0);
            check("t4_hold_cnt", 32'(lookup_cnt), 32'd19);
        end
        out_ready = 1'b1; in_data = 4'h9;
        tick();
        check("t4_resume", 32'(out_data), 32'h09);
        check("t4_resume_cnt", 32'(lookup_cnt), 32'd20);
        in_valid = 1'b0;
        tick();

        // random traffic: lookups, writes, backpressure
        for (int c = 0; c < 600; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = IN_W'($urandom_range(0, DEPTH - 1));
            out_ready = ($urandom_range(0, 3) != 0);
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = IN_W'($urandom_range(0, DEPTH - 1));
            wr_data   = OUT_W'($urandom_range(0, (1 << OUT_W) - 1));
            if ($urandom_range(0, 7) == 0) wr_addr = in_data;
            tick();
        end
        drive_idle();
        tick();

        // 5: reset mid-stream, writes during INIT are ignored
        in_valid = 1'b1; in_data = 4'h4; out_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_done", 32'(init_done), 32'd0);
        tick();
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 4'h2; wr_data = 6'h3F;
        n = 0;
        while (init_done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("t5_init_len", 32'(n), 32'(DEPTH));
        drive_idle();
        lookup(2);
        check("t5_entry2", 32'(out_data), 32'h02);
        lookup(3);
        check("t5_entry3_reswept", 32'(out_data), 32'h03);
        tick();

        // 6: counter wrap after 65537 accepted lookups
        do_reset_and_init(n);
        in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (acc_count < 65537 && n < 70000) begin
            in_data = IN_W'($urandom_range(0, DEPTH - 1));
            tick();
            n++;
        end
        check("t6_accepts", 32'(acc_count), 32'd65537);
        check("t6_wrap", 32'(lookup_cnt), 32'd1);
        in_valid = 1'b0;
        tick();

        // 6b: narrow instance, all-zero defaults
        rst_b = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        n = 0;
        while (init_done_b !== 1'b1 && n < 40) begin
            check("b_ready_init", 32'(in_ready_b), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check("b_init_len", 32'(n), 32'd8);
        out_ready_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid_b = 1'b1;
            in_data_b  = 3'(i);
            @(posedge clk); #1;
            check("b_valid", 32'(out_valid_b), 32'd1);
            check("b_zero", 32'(out_data_b), 32'd0);
        end
        in_valid_b = 1'b0;
        @(posedge clk); #1;
        check("b_cnt", 32'(lookup_cnt_b), 32'd8);
        check("b_drain", 32'(out_valid_b), 32'd0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
